// File: rtl/uart_rx_port.sv
// 8N1 serial receiver on the CPU bus: 2-flop synchroniser, bit FSM, byte FIFO, registered read (1 cycle).
// Full FIFO drops new bytes and sets ovr; UART_RX_IRQ_EN adds the irqen bit and the registered irq output.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       sel,
    input  logic       addr,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
`ifdef UART_RX_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BCW   = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0]   BC_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]   BC_MID   = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_LAST = (FIFO_AW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [BCW-1:0]   bc_q, bc_d;
    logic [2:0]       bi_q, bi_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [FIFO_AW:0] wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d;
    logic [7:0]       dout_q, dout_d;
    logic             push, ferr_set, pop, do_push, empty, full, irqen_bit;
    logic [7:0]       status;
    logic             unused_wdat;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_FULL);
    assign status   = {irqen_bit, 3'b000, ferr_q, ovr_q, full, ~empty};
    assign data_out = dout_q;

    // Receiver FSM; bc/bi only advance outside IDLE and BRK.
    always_comb begin
        state_d  = state_q;
        bc_d     = bc_q;
        bi_d     = bi_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                bc_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (bc_q == BC_MID) begin
                    bc_d    = '0;
                    bi_d    = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bc_q == BC_LAST) begin
                    bc_d = '0;
                    sh_d = {rx_s_q, sh_q[7:1]};
                    if (bi_q == 3'd7) state_d = S_STOP;
                    else              bi_d    = bi_q + 1'b1;
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bc_q == BC_LAST) begin
                    bc_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BRK;
                    end
                end else begin
                    bc_d = bc_q + 1'b1;
                end
            end
            S_BRK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO, sticky flags and bus read mux; a flag set in the same cycle as its clear wins.
    always_comb begin
        pop     = sel && !we && !addr && !empty;
        do_push = push && (!full || pop);
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        dout_d  = dout_q;
        if (do_push) begin
            mem_d[wp_q[FIFO_AW-1:0]] = sh_q;
            wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
        end
        if (pop) rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
        if (do_push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !do_push) cnt_d = cnt_q - 1'b1;
        if (sel && we && addr) begin
            if (data_in[2]) ovr_d  = 1'b0;
            if (data_in[3]) ferr_d = 1'b0;
        end
        if (push && full && !pop) ovr_d  = 1'b1;
        if (ferr_set)             ferr_d = 1'b1;
        if (sel && !we) begin
            if (addr)       dout_d = status;
            else if (empty) dout_d = 8'h00;
            else            dout_d = mem_q[rp_q[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            bc_q      <= '0;
            bi_q      <= '0;
            sh_q      <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            bc_q      <= bc_d;
            bi_q      <= bi_d;
            sh_q      <= sh_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            dout_q    <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef UART_RX_IRQ_EN
    logic irqen_q, irqen_d, irq_q, irq_d;

    assign irqen_bit   = irqen_q;
    assign irq         = irq_q;
    assign unused_wdat = ^{data_in[6:4], data_in[1:0]};

    always_comb begin
        irqen_d = irqen_q;
        if (sel && we && addr) irqen_d = data_in[7];
        irq_d = irqen_q && !empty;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end
`else
    assign irqen_bit   = 1'b0;
    assign unused_wdat = ^{data_in[7:4], data_in[1:0]};
`endif

endmodule

// File: tb/tb_uart_rx_port.sv
module tb_uart_rx_port;
    localparam int CPB   = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       reset, rx, sel, addr, we;
    logic [7:0] data_in, data_out;
`ifdef UART_RX_IRQ_EN
    logic       irq;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] hold_exp = 8'h00;
    bit         chk_en = 1'b0;
    string      cur_name = "reset";

    // Reference model: byte queue plus sticky flags.
    logic [7:0] m_q[$];
    bit         m_ovr = 0, m_ferr = 0, m_irqen = 0;

    uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .sel(sel), .addr(addr),
        .we(we), .data_in(data_in), .data_out(data_out)
`ifdef UART_RX_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_push(input logic [7:0] b);
        if (m_q.size() == DEPTH) m_ovr = 1;
        else m_q.push_back(b);
    endfunction

    function automatic logic [7:0] model_read(input logic a);
        logic [7:0] r;
        if (a) begin
            r = {m_irqen, 3'b000, m_ferr, m_ovr, (m_q.size() == DEPTH), (m_q.size() != 0)};
        end else if (m_q.size() != 0) begin
            r = m_q.pop_front();
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    function automatic void model_write(input logic a, input logic [7:0] d);
        if (a) begin
            if (d[2]) m_ovr = 0;
            if (d[3]) m_ferr = 0;
`ifdef UART_RX_IRQ_EN
            m_irqen = d[7];
`endif
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ovr = 0;
        m_ferr = 0;
        m_irqen = 0;
    endfunction

    function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endfunction

    // data_out must equal the last expected read value on every cycle.
    always @(negedge clk) begin
        if (chk_en) check({"data_out/", cur_name}, data_out, hold_exp);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic a, input logic [7:0] lit, input bit has_lit, input string nm);
        logic [7:0] e;
        sel = 1; we = 0; addr = a;
        e = model_read(a);
        tick(1);
        sel = 0;
        hold_exp = e;
        cur_name = nm;
        if (has_lit) check(nm, data_out, lit);
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        sel = 1; we = 1; addr = a; data_in = d;
        tick(1);
        sel = 0; we = 0;
        model_write(a, d);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stop_low);
        rx = 0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        if (stop_low > 0) begin
            rx = 0;
            tick(CPB * stop_low);
        end
        rx = 1;
        tick(CPB * 2);
        if (stop_low > 0) m_ferr = 1;
        else model_push(b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; rx = 1; sel = 0; addr = 0; we = 0; data_in = 8'h00;
        tick(2);
        hold_exp = 8'h00;
        chk_en = 1;
        reset = 1;
        tick(2);

        rd(1, 8'h00, 1, "reset_status");
        rd(0, 8'h00, 1, "reset_data");

        send_byte(8'hA5, 0);
        rd(1, 8'h01, 1, "single_status");
        rd(0, 8'hA5, 1, "single_data");
        rd(1, 8'h00, 1, "single_status_after");

        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 0);
        wr(0, 8'hFF);
        rd(1, 8'h07, 1, "fill_status");
        for (int i = 0; i < DEPTH; i++) rd(0, 8'(i), 1, "fill_data");
        rd(0, 8'h00, 1, "fill_empty_data");
        rd(1, 8'h04, 1, "ovr_sticky");
        wr(1, 8'h04);
        rd(1, 8'h00, 1, "ovr_cleared");

        send_byte(8'h3C, 2);
        rd(1, 8'h08, 1, "ferr_status");
        wr(1, 8'h08);
        rd(1, 8'h00, 1, "ferr_cleared");
        send_byte(8'h11, 0);
        rd(1, 8'h01, 1, "after_ferr_status");
        rd(0, 8'h11, 1, "after_ferr_data");

        rx = 0;
        tick(3);
        rx = 1;
        tick(CPB * 12);
        rd(1, 8'h00, 1, "glitch_status");

        // A byte left in the FIFO must be discarded by the mid-frame reset.
        send_byte(8'h77, 0);
        rx = 0;
        tick(CPB);
        rx = 1;
        tick(CPB * 4 + CPB / 2);
        reset = 0;
        tick(1);
        hold_exp = 8'h00;
        cur_name = "midframe_reset";
        model_reset();
        tick(1);
        reset = 1;
        tick(CPB * 6);
        send_byte(8'h5A, 0);
        rd(1, 8'h01, 1, "midreset_status");
        rd(0, 8'h5A, 1, "midreset_data");
        rd(1, 8'h00, 1, "midreset_status_after");

`ifdef UART_RX_IRQ_EN
        wr(1, 8'h80);
        rd(1, 8'h80, 1, "irqen_readback");
        check("irq_idle", {7'd0, irq}, 8'h00);
        rx = 0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = 1'((8'h42 >> i) & 8'h01);
            tick(CPB);
        end
        rx = 1;
        tick(CPB / 2);
        check("irq_before_push", {7'd0, irq}, 8'h00);
        tick(CPB / 2);
        check("irq_after_push", {7'd0, irq}, 8'h01);
        model_push(8'h42);
        tick(CPB);
        rd(0, 8'h42, 1, "irq_data");
        check("irq_lags_pop", {7'd0, irq}, 8'h01);
        tick(1);
        check("irq_fall", {7'd0, irq}, 8'h00);
`endif

        tick(4);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
